// File: rtl/seq_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// seq_multiplier_pkg
//   Shared definitions for the sequential multiplier:
//     XLEN     - operand / product width (64)
//     CNT_W    - width of the iteration counter (6 bits, counts 0..63)
//     state_t  - FSM state encoding (IDLE, RUN, DONE)
// -----------------------------------------------------------------------------
package seq_multiplier_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : seq_multiplier_pkg

// File: rtl/seq_multiplier_adder.sv
// -----------------------------------------------------------------------------
// bit64_adder
//   Purely combinational XLEN-bit adder used as the accumulate stage of the
//   sequential multiplier.
//   Ports:
//     a, b     in   XLEN  addends
//     sum      out  XLEN  a + b, wrapped to XLEN bits
//     carry    out  1     unsigned carry out of the top bit
//     overflow out  1     signed (two's-complement) overflow
// -----------------------------------------------------------------------------
module bit64_adder
  import seq_multiplier_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] sum,
  output logic            carry,
  output logic            overflow
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

  // Signed overflow: both addends share a sign that the result does not.
  assign overflow = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);

endmodule : bit64_adder

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Shift-and-add multiplier producing the low XLEN bits of a*b (RV64 MUL
//   semantics; identical for signed and unsigned operands). One multiplier
//   bit is consumed per RUN cycle. With EARLY_EXIT=1 the run stops as soon
//   as no set multiplier bits remain, otherwise it always takes 64 cycles.
//   Parameters:
//     EARLY_EXIT  1 = stop when remaining multiplier is zero, 0 = 64 iterations
//   Ports:
//     clk      in   1     system clock, rising edge
//     rst_n    in   1     asynchronous active-low reset
//     start    in   1     request a multiply (sampled only while ready=1)
//     cancel   in   1     abort the current operation / suppress a start
//     a        in   XLEN  multiplicand
//     b        in   XLEN  multiplier
//     ready    out  1     high only in IDLE
//     busy     out  1     high in RUN
//     done     out  1     one-cycle pulse, product valid
//     product  out  XLEN  registered low XLEN bits of a*b
// -----------------------------------------------------------------------------
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int EARLY_EXIT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            cancel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  state_t             state;
  logic [XLEN-1:0]    mcand;
  logic [XLEN-1:0]    mplier;
  logic [XLEN-1:0]    acc;
  logic [CNT_W-1:0]   count;

  logic [XLEN-1:0]    addend;
  logic [XLEN-1:0]    acc_next;
  logic [XLEN-1:0]    mplier_next;
  logic               last_iter;
  logic               adder_carry_unused;
  logic               adder_overflow_unused;

  // Multiplicand is added only when the current multiplier bit is set.
  assign addend      = mcand & {XLEN{mplier[0]}};
  assign mplier_next = mplier >> 1;

  // The final iteration is either the 64th one, or (early exit) the one that
  // shifts the last set bit out of the multiplier.
  assign last_iter = (count == CNT_W'(XLEN - 1)) ||
                     ((EARLY_EXIT != 0) && (mplier_next == '0));

  bit64_adder u_adder (
    .a        (acc),
    .b        (addend),
    .sum      (acc_next),
    .carry    (adder_carry_unused),
    .overflow (adder_overflow_unused)
  );

  // NOTE: all state lives in this one clocked block and is updated with
  // non-blocking assignments, so every right-hand side sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // cancel has priority: a simultaneous start is dropped.
          if (start && !cancel) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            state  <= RUN;
            ready  <= 1'b0;
            busy   <= 1'b1;
          end
        end

        RUN: begin
          if (cancel) begin
            // Abort: product and done are left untouched.
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier_next;
            // Hold at 63 instead of wrapping; RUN is always left at that point.
            if (count != CNT_W'(XLEN - 1)) begin
              count <= count + 1'b1;
            end
            if (last_iter) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              product <= acc_next;
            end
          end
        end

        DONE: begin
          // Single-cycle pulse; cancel here leads to the same place.
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end

        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule : seq_multiplier
